// File: rtl/wrr_burst_arbiter_pkg.sv
// wrr_burst_arbiter_pkg: shared defaults, types and FSM states for the weighted round-robin arbiter
// Contents:
//   ARB_N, ARB_WW, ARB_IW  default requester count, weight width, index width
//   weight_t, idx_t        weight-table entry and requester index types
//   arb_state_t            IDLE (no grant) / GRANT (a requester holds the resource)
package wrr_burst_arbiter_pkg;
    localparam int ARB_N  = 16;
    localparam int ARB_WW = 4;
    localparam int ARB_IW = $clog2(ARB_N);
    typedef logic [ARB_WW-1:0] weight_t;
    typedef logic [ARB_IW-1:0] idx_t;
    typedef enum logic {IDLE, GRANT} arb_state_t;
endpackage

// File: rtl/wrr_burst_arbiter_if.sv
// wrr_burst_arbiter_if: request, weight-write and grant signals between masters and the arbiter
// Signals:
//   req          N   level-sensitive request vector
//   weight_wr    1   weight table write strobe
//   weight_idx   IW  weight table entry to write
//   weight_data  WW  burst length to store
//   gnt          N   one-hot grant or all zero
//   gnt_valid    1   gnt != 0
//   gnt_id       IW  index of the granted requester, 0 when idle
//   burst_last   1   final permitted cycle of the current burst
// Modports: master drives requests and weight writes; slave is the arbiter.
interface wrr_burst_arbiter_if
    import wrr_burst_arbiter_pkg::*;
#(
    parameter int N  = ARB_N,
    parameter int WW = ARB_WW
) ();
    localparam int IW = $clog2(N);
    logic [N-1:0]  req;
    logic          weight_wr;
    logic [IW-1:0] weight_idx;
    logic [WW-1:0] weight_data;
    logic [N-1:0]  gnt;
    logic          gnt_valid;
    logic [IW-1:0] gnt_id;
    logic          burst_last;
    modport master (
        output req, weight_wr, weight_idx, weight_data,
        input  gnt, gnt_valid, gnt_id, burst_last
    );
    modport slave (
        input  req, weight_wr, weight_idx, weight_data,
        output gnt, gnt_valid, gnt_id, burst_last
    );
endinterface

// File: rtl/wrr_burst_arbiter_rr_pick.sv
// rr_pick: combinational rotating priority encoder
// Ports:
//   req_i    N   request vector
//   ptr_i    IW  index with highest priority; search runs upward from here, wrapping modulo N
//   found_o  1   any request set
//   idx_o    IW  index of the first set request from ptr_i, 0 when none
module rr_pick #(
    parameter int N  = 16,
    parameter int IW = $clog2(N)
) (
    input  logic [N-1:0]  req_i,
    input  logic [IW-1:0] ptr_i,
    output logic          found_o,
    output logic [IW-1:0] idx_o
);
    always_comb begin
        int j;
        j = 0;
        found_o = 1'b0;
        idx_o = '0;
        // Scan from the farthest offset down so the nearest set bit to ptr_i is written last.
        for (int k = N - 1; k >= 0; k--) begin
            j = (int'(ptr_i) + k) % N;
            if (req_i[j]) begin
                found_o = 1'b1;
                idx_o = IW'(j);
            end
        end
    end
endmodule

// File: rtl/wrr_burst_arbiter.sv
// wrr_burst_arbiter: weighted round-robin arbiter; each winner holds the grant for up to weight[i] cycles
// Ports:
//   clk   clock, all logic on posedge
//   rst   synchronous active-high reset; clears grant, pointer, counter and restores all weights to 1
//   bus   slave side of wrr_burst_arbiter_if (requests, weight writes, registered grant outputs)
module wrr_burst_arbiter
    import wrr_burst_arbiter_pkg::*;
#(
    parameter int N  = ARB_N,
    parameter int WW = ARB_WW
) (
    input logic                clk,
    input logic                rst,
    wrr_burst_arbiter_if.slave bus
);
    localparam int IW = $clog2(N);

    arb_state_t    state_q, state_d;
    logic [IW-1:0] ptr_q, ptr_d;
    logic [WW-1:0] cnt_q, cnt_d;
    logic [N-1:0]  gnt_q, gnt_d;
    logic [IW-1:0] gnt_id_q, gnt_id_d;
    logic          gnt_valid_q, gnt_valid_d;
    logic          burst_last_q, burst_last_d;
    logic [WW-1:0] weight_q [N];

    logic [IW-1:0] h_next, pick_ptr, win;
    logic          found, burst_end;

    assign h_next = (gnt_id_q == IW'(N - 1)) ? '0 : gnt_id_q + 1'b1;
    assign burst_end = (state_q == GRANT) && (!bus.req[gnt_id_q] || cnt_q == '0);
    // At burst end the search starts just past the holder, so it wins again only when alone.
    assign pick_ptr = (state_q == GRANT) ? h_next : ptr_q;

    rr_pick #(.N(N), .IW(IW)) u_pick (
        .req_i  (bus.req),
        .ptr_i  (pick_ptr),
        .found_o(found),
        .idx_o  (win)
    );

    always_comb begin
        state_d = state_q;
        ptr_d = ptr_q;
        cnt_d = cnt_q;
        gnt_id_d = gnt_id_q;
        gnt_valid_d = gnt_valid_q;
        if (state_q == IDLE || burst_end) begin
            ptr_d = burst_end ? h_next : ptr_q;
            state_d = found ? GRANT : IDLE;
            gnt_valid_d = found;
            gnt_id_d = found ? win : '0;
            // Weight 0 behaves as 1; the table read here is the pre-write value on a write edge.
            cnt_d = (found && weight_q[win] != '0) ? weight_q[win] - 1'b1 : '0;
        end else begin
            cnt_d = cnt_q - 1'b1;
        end
        gnt_d = gnt_valid_d ? N'(1) << gnt_id_d : '0;
        burst_last_d = gnt_valid_d && cnt_d == '0;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            ptr_q <= '0;
            cnt_q <= '0;
            gnt_q <= '0;
            gnt_id_q <= '0;
            gnt_valid_q <= 1'b0;
            burst_last_q <= 1'b0;
        end else begin
            state_q <= state_d;
            ptr_q <= ptr_d;
            cnt_q <= cnt_d;
            gnt_q <= gnt_d;
            gnt_id_q <= gnt_id_d;
            gnt_valid_q <= gnt_valid_d;
            burst_last_q <= burst_last_d;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < N; i++) weight_q[i] <= WW'(1);
        end else if (bus.weight_wr && 32'(bus.weight_idx) < N) begin
            weight_q[bus.weight_idx] <= bus.weight_data;
        end
    end

    assign bus.gnt = gnt_q;
    assign bus.gnt_valid = gnt_valid_q;
    assign bus.gnt_id = gnt_id_q;
    assign bus.burst_last = burst_last_q;
endmodule

// File: tb/tb_wrr_burst_arbiter.sv
// tb_wrr_burst_arbiter: directed self-checking bench for wrr_burst_arbiter
module tb_wrr_burst_arbiter;
    import wrr_burst_arbiter_pkg::*;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int checks = 0;
    int errors = 0;

    wrr_burst_arbiter_if bus ();

    wrr_burst_arbiter dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    always #5 clk = ~clk;

    task automatic do_reset();
        rst = 1'b1;
        bus.req = '0;
        bus.weight_wr = 1'b0;
        bus.weight_idx = '0;
        bus.weight_data = '0;
        repeat (2) @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic write_w(input idx_t i, input weight_t d);
        bus.weight_wr = 1'b1;
        bus.weight_idx = i;
        bus.weight_data = d;
        @(negedge clk);
        bus.weight_wr = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        bus.req = 16'hFFFF;
        bus.weight_wr = 1'b0;
        bus.weight_idx = '0;
        bus.weight_data = '0;
        for (int c = 0; c < 10; c++) begin
            @(negedge clk);
            checks++;
            if (bus.gnt !== 16'h0000 || bus.gnt_valid !== 1'b0 || bus.gnt_id !== 4'd0 || bus.burst_last !== 1'b0) begin
                errors++;
                $display("FAIL reset_hold c%0d gnt=%h v=%b id=%0d bl=%b expected 0000/0/0/0",
                         c, bus.gnt, bus.gnt_valid, bus.gnt_id, bus.burst_last);
            end
        end
        rst = 1'b0;
        @(negedge clk);
        checks++;
        if (bus.gnt !== 16'h0001 || bus.gnt_valid !== 1'b1 || bus.gnt_id !== 4'd0) begin
            errors++;
            $display("FAIL reset_release gnt=%h v=%b id=%0d expected 0001/1/0", bus.gnt, bus.gnt_valid, bus.gnt_id);
        end
    endtask

    task automatic test_default_rr();
        do_reset();
        bus.req = 16'hFFFF;
        for (int i = 0; i < 17; i++) begin
            logic [3:0] eid;
            logic [15:0] eg;
            eid = 4'(i % 16);
            eg = 16'h0001 << eid;
            @(negedge clk);
            checks++;
            if (bus.gnt_id !== eid || bus.gnt !== eg || bus.burst_last !== 1'b1) begin
                errors++;
                $display("FAIL default_rr i%0d id=%0d gnt=%h bl=%b expected %0d/%h/1",
                         i, bus.gnt_id, bus.gnt, bus.burst_last, eid, eg);
            end
        end
    endtask

    task automatic test_weighted();
        int exp_id [10] = '{3, 3, 3, 3, 4, 3, 3, 3, 3, 4};
        logic exp_bl [10] = '{0, 0, 0, 1, 1, 0, 0, 0, 1, 1};
        do_reset();
        write_w(4'd3, 4'd4);
        bus.req = 16'h0018;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            checks++;
            if (bus.gnt_id !== 4'(exp_id[i]) || bus.burst_last !== exp_bl[i] || bus.gnt_valid !== 1'b1) begin
                errors++;
                $display("FAIL weighted i%0d id=%0d bl=%b v=%b expected %0d/%b/1",
                         i, bus.gnt_id, bus.burst_last, bus.gnt_valid, exp_id[i], exp_bl[i]);
            end
        end
    endtask

    task automatic test_drop();
        do_reset();
        write_w(4'd5, 4'd8);
        bus.req = 16'h0020;
        for (int c = 0; c < 4; c++) begin
            @(negedge clk);
            checks++;
            if (bus.gnt !== 16'h0020 || bus.burst_last !== 1'b0) begin
                errors++;
                $display("FAIL drop_hold c%0d gnt=%h bl=%b expected 0020/0", c, bus.gnt, bus.burst_last);
            end
            if (c == 3) bus.req = '0;
        end
        @(negedge clk);
        checks++;
        if (bus.gnt !== 16'h0000 || bus.gnt_valid !== 1'b0 || bus.gnt_id !== 4'd0 || bus.burst_last !== 1'b0) begin
            errors++;
            $display("FAIL drop_release gnt=%h v=%b id=%0d bl=%b expected 0000/0/0/0",
                     bus.gnt, bus.gnt_valid, bus.gnt_id, bus.burst_last);
        end
    endtask

    task automatic test_walking();
        logic [15:0] cur;
        do_reset();
        cur = 16'h0002;
        bus.req = cur;
        for (int k = 0; k < 16; k++) begin
            @(negedge clk);
            checks++;
            if (bus.gnt !== cur || !$onehot0(bus.gnt)) begin
                errors++;
                $display("FAIL walking k%0d gnt=%h expected %h", k, bus.gnt, cur);
            end
            cur = {cur[14:0], cur[15]};
            bus.req = cur;
        end
        bus.req = '0;
    endtask

    task automatic test_same_edge_weight();
        logic exp_bl [4] = '{1, 0, 0, 1};
        do_reset();
        bus.req = 16'h0001;
        bus.weight_wr = 1'b1;
        bus.weight_idx = 4'd0;
        bus.weight_data = 4'd3;
        for (int c = 0; c < 4; c++) begin
            @(negedge clk);
            bus.weight_wr = 1'b0;
            checks++;
            if (bus.gnt !== 16'h0001 || bus.burst_last !== exp_bl[c]) begin
                errors++;
                $display("FAIL same_edge_weight c%0d gnt=%h bl=%b expected 0001/%b", c, bus.gnt, bus.burst_last, exp_bl[c]);
            end
        end
    endtask

    task automatic test_reset_midburst();
        do_reset();
        write_w(4'd0, 4'd5);
        bus.req = 16'h0001;
        for (int c = 0; c < 2; c++) begin
            @(negedge clk);
            checks++;
            if (bus.gnt !== 16'h0001 || bus.burst_last !== 1'b0) begin
                errors++;
                $display("FAIL midburst_hold c%0d gnt=%h bl=%b expected 0001/0", c, bus.gnt, bus.burst_last);
            end
        end
        rst = 1'b1;
        @(negedge clk);
        checks++;
        if (bus.gnt !== 16'h0000 || bus.gnt_valid !== 1'b0) begin
            errors++;
            $display("FAIL midburst_reset gnt=%h v=%b expected 0000/0", bus.gnt, bus.gnt_valid);
        end
        rst = 1'b0;
        @(negedge clk);
        checks++;
        if (bus.gnt !== 16'h0001 || bus.burst_last !== 1'b1) begin
            errors++;
            $display("FAIL midburst_weight_revert gnt=%h bl=%b expected 0001/1", bus.gnt, bus.burst_last);
        end
        bus.req = '0;
    endtask

    initial begin
        test_reset();
        test_default_rr();
        test_weighted();
        test_drop();
        test_walking();
        test_same_edge_weight();
        test_reset_midburst();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
